opsum_ppu: RTL and testbench
============================

# opsum_ppu

Post-processing unit directly downstream of a PE's opsum port. Consumes 32-bit signed partial sums over a valid/ready handshake and applies a rounded arithmetic right shift, optional ReLU, and int8 saturation. It then converts each result back to offset-binary (uint8, XOR 0x80) and packs four results into one 32-bit word for the global buffer write path. A 2-entry output FIFO decouples the PE from global-buffer backpressure.

## Interface
Parameters:
- `DATA_BITS`, 32: opsum and output word width.
- `FIFO_DEPTH`, 2: output word FIFO entries.

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: pulse; latches config while IDLE, ignored otherwise.
- `cfg_shift` input 5: right-shift amount, 0..31.
- `cfg_relu` input 1: 1 = clamp negative results to 0.
- `opsum` input 32: signed partial sum from PE.
- `opsum_valid` input 1: opsum valid.
- `opsum_last` input 1: qualifies final opsum of the pass; sampled with the handshake.
- `opsum_ready` output 1: unit accepts opsum.
- `out_data` output 32: packed word; byte k in bits [8k+7:8k].
- `out_valid` output 1: out_data valid (FIFO non-empty).
- `out_last` output 1: word contains the final opsum.
- `out_ready` input 1: downstream accepts word.
- `done` output 1: one-cycle pulse after last word is popped.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN on `start`. Latch cfg_shift/cfg_relu. Clear byte counter and pack register.
- RUN -> DRAIN on accepted opsum with opsum_last=1.
- DRAIN -> IDLE when FIFO is empty. Assert `done` for exactly one cycle in that transition.
- Accept: `opsum_valid && opsum_ready`. `opsum_ready = (state==RUN) && (fifo_count < FIFO_DEPTH)`. It is registered-state only, with no combinational path from out_ready.
- Arithmetic per accepted value, 34-bit signed intermediate:
  - r = opsum + (cfg_shift ? 1<<(cfg_shift-1) : 0).
  - r = r >>> cfg_shift.
  - If cfg_relu and r<0, r=0.
  - Saturate to [-128,127].
  - byte = r[7:0] ^ 8'h80.
- Packing:
  - Byte goes to lane = byte counter (0..3). Counter increments per accept.
  - On 4th byte, or on opsum_last, push {pack register with new byte} to FIFO in the same edge. Unfilled upper lanes are 0x00. out_last = opsum_last.
  - Clear pack register and counter after each push.
- FIFO: in-order. Simultaneous push and pop is allowed at any count, including full (pop frees the slot the same edge, but opsum_ready still uses the pre-edge count).
- `start` outside IDLE: ignored. Config changes outside IDLE: no effect.
- opsum_valid while IDLE/DRAIN: not accepted, no state change.

## Timing
- Reset values:
  - State IDLE.
  - opsum_ready=0, out_valid=0, out_data=0, out_last=0, done=0.
  - FIFO empty, counter 0, pack register 0.
- opsum_ready rises the cycle after `start`.
- Latency: completing accept in cycle t -> out_valid=1 in cycle t+1.
- Throughput: one opsum per cycle while FIFO is not full.
- Reset asserted mid-operation: everything returns to reset values immediately. Partial words and FIFO contents are discarded.

## Structure
- Package `ppu_pkg`: DATA_BITS, state encoding, shift width (5), int8 saturation bounds, offset constant 8'h80.
- Sub-module `word_fifo`: parametric sync FIFO (depth, width 33 = data+last), with count output and async active-low reset.
- Arithmetic stays combinational in `opsum_ppu`; there is no extra pipeline stage.

## Test plan
- shift=0, relu=0, opsums 1,2,3,4, last on 4th -> single word 0x84838281, out_last=1; done pulses one cycle after pop.
- shift=4 rounding: 24, -24, 8, -9, last -> bytes 2,-1,1,-1 -> 0x7F817F82, out_last=1.
- Saturation/ReLU: shift=0, relu=0: 1000,-1000 -> 0xFF,0x00. relu=1: -5,300 -> 0x80,0xFF. Check both packed words.
- Partial flush: shift=0, values 1..6, last on 6th -> 0x84838281 then 0x00008685; out_last only on second.
- Backpressure: out_ready=0, 12 values offered -> opsum_ready drops after 8 accepts (FIFO full). Release out_ready -> 3 words in order, no loss or duplication.
- Reset mid-RUN after 2 accepts -> all outputs reset next cycle. A new `start` plus 4 values produces a clean word with no stale bytes.

Source files
------------

// File: rtl/opsum_ppu_pkg.sv
// Shared constants and state encoding for the opsum post-processing unit.
// Saturation bounds are plain ints so each user can size them to its own accumulator.
package ppu_pkg;

    localparam int DATA_BITS = 32;
    localparam int SHIFT_W   = 5;
    localparam int SAT_MAX   = 127;
    localparam int SAT_MIN   = -128;

    localparam logic [7:0] OFFSET = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/opsum_ppu_word_fifo.sv
// Small in-order synchronous FIFO carrying packed words plus their last flag.
// Storage is not reset; the read port reads as zero whenever the FIFO is empty.
module word_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 33,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A pop frees its slot in the same edge, so a push into a full FIFO is legal then.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count < CW'(DEPTH)) || w_do_pop);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= ptr_inc(r_wr);
            end
            if (w_do_pop) begin
                r_rd <= ptr_inc(r_rd);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = (r_count != '0) ? r_mem[r_rd] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/opsum_ppu.sv
// Opsum post-processing: rounded shift, optional ReLU, int8 saturation, offset-binary
// conversion and four-lane packing into a small output FIFO.
module opsum_ppu
    import ppu_pkg::*;
#(
    parameter int DATA_BITS  = ppu_pkg::DATA_BITS,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [SHIFT_W-1:0]   cfg_shift,
    input  logic                 cfg_relu,
    input  logic [DATA_BITS-1:0] opsum,
    input  logic                 opsum_valid,
    input  logic                 opsum_last,
    output logic                 opsum_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 done
);

    localparam int AW    = DATA_BITS + 2;
    localparam int LANES = DATA_BITS / 8;
    localparam int NW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    localparam logic signed [AW-1:0] W_MAX = AW'(SAT_MAX);
    localparam logic signed [AW-1:0] W_MIN = AW'(SAT_MIN);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SHIFT_W-1:0]     r_shift;
    logic                   r_relu;
    logic [NW-1:0]          r_cnt;
    logic [DATA_BITS-1:0]   r_pack;
    logic [DATA_BITS-1:0]   w_word;
    logic [7:0]             w_byte;
    logic                   w_accept;
    logic                   w_push;
    logic [CW-1:0]          w_count;
    logic [DATA_BITS:0]     w_fifo_out;

    function automatic logic signed [AW-1:0] round_shift(
        input logic [DATA_BITS-1:0] v,
        input logic [SHIFT_W-1:0]   sh
    );
        logic signed [AW-1:0] r;
        logic signed [AW-1:0] one;
        one = AW'(1);
        r   = {{2{v[DATA_BITS-1]}}, v};
        if (sh != '0) begin
            r = r + (one <<< (sh - SHIFT_W'(1)));
        end
        return r >>> sh;
    endfunction

    function automatic logic [7:0] relu_sat_u8(
        input logic signed [AW-1:0] v,
        input logic                 relu
    );
        logic signed [AW-1:0] r;
        r = v;
        if (relu && (r < 0)) begin
            r = '0;
        end
        if (r > W_MAX) begin
            r = W_MAX;
        end else if (r < W_MIN) begin
            r = W_MIN;
        end
        return r[7:0] ^ OFFSET;
    endfunction

    // Ready depends only on registered state and the pre-edge FIFO count.
    assign opsum_ready = (r_state == ST_RUN) && (w_count < CW'(FIFO_DEPTH));
    assign w_accept    = opsum_valid && opsum_ready;
    assign w_byte      = relu_sat_u8(round_shift(opsum, r_shift), r_relu);
    assign w_push      = w_accept && ((r_cnt == NW'(LANES - 1)) || opsum_last);

    always_comb begin
        w_word = r_pack;
        w_word[8*r_cnt +: 8] = w_byte;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_accept && opsum_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_count == '0) begin
                    w_state_nxt = ST_IDLE;
                    done        = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= '0;
            r_relu  <= 1'b0;
            r_cnt   <= '0;
            r_pack  <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_shift <= cfg_shift;
            r_relu  <= cfg_relu;
            r_cnt   <= '0;
            r_pack  <= '0;
        end else if (w_accept) begin
            if (w_push) begin
                r_cnt  <= '0;
                r_pack <= '0;
            end else begin
                r_cnt  <= r_cnt + NW'(1);
                r_pack <= w_word;
            end
        end
    end

    word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS + 1),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .i_rst_n (rst),
        .i_push  (w_push),
        .i_data  ({opsum_last, w_word}),
        .i_pop   (out_ready),
        .o_data  (w_fifo_out),
        .o_count (w_count)
    );

    assign out_valid = (w_count != '0);
    assign out_data  = w_fifo_out[DATA_BITS-1:0];
    assign out_last  = w_fifo_out[DATA_BITS];

endmodule

// File: tb/tb_opsum_ppu.sv
// Directed bench for opsum_ppu with hand-computed packed words.
module tb_opsum_ppu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  cfg_shift;
    logic        cfg_relu;
    logic [31:0] opsum;
    logic        opsum_valid;
    logic        opsum_last;
    logic        opsum_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;
    int acc_cnt  = 0;
    logic [32:0] q[$];

    opsum_ppu #(.DATA_BITS(32), .FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_shift   (cfg_shift),
        .cfg_relu    (cfg_relu),
        .opsum       (opsum),
        .opsum_valid (opsum_valid),
        .opsum_last  (opsum_last),
        .opsum_ready (opsum_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs only change just after a rising edge, so the falling edge sees the handshake.
    always @(negedge clk) begin
        if (out_valid && out_ready) q.push_back({out_last, out_data});
        if (opsum_valid && opsum_ready) acc_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [4:0] sh, input logic relu);
        cfg_shift = sh;
        cfg_relu  = relu;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic send(input logic [31:0] v, input logic l, input int budget, output bit ok);
        opsum       = v;
        opsum_last  = l;
        opsum_valid = 1'b1;
        ok          = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (opsum_ready) begin
                ok = 1'b1;
                step();
                break;
            end
            step();
        end
        opsum_valid = 1'b0;
        opsum_last  = 1'b0;
    endtask

    task automatic send_chk(input string tag, input logic [31:0] v, input logic l);
        bit ok;
        send(v, l, 20, ok);
        check(tag, ok, 1'b1);
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check(tag, seen, 1'b1);
        step();
    endtask

    task automatic pop_chk(input string tag, input logic [32:0] exp);
        logic [32:0] w;
        if (q.size() == 0) begin
            check(tag, 64'hDEAD, exp);
        end else begin
            w = q.pop_front();
            check(tag, w, exp);
        end
    endtask

    initial begin
        bit ok;
        rst = 1'b0; start = 1'b0; cfg_shift = '0; cfg_relu = 1'b0;
        opsum = '0; opsum_valid = 1'b0; opsum_last = 1'b0; out_ready = 1'b1;
        step(); step();
        check("rst_ready", opsum_ready, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_done", done, 0);
        rst = 1'b1;
        step();

        // valid while idle is ignored
        opsum = 32'd5; opsum_valid = 1'b1; step(); step();
        opsum_valid = 1'b0;
        check("idle_noacc", acc_cnt, 0);
        check("idle_ready", opsum_ready, 0);

        // basic pack, latency and done timing
        do_start(5'd0, 1'b0);
        check("t1_ready", opsum_ready, 1);
        send_chk("t1_s1", 32'd1, 0);
        send_chk("t1_s2", 32'd2, 0);
        send_chk("t1_s3", 32'd3, 0);
        send_chk("t1_s4", 32'd4, 1);
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 32'h84838281);
        check("t1_last", out_last, 1);
        check("t1_drain_ready", opsum_ready, 0);
        step();
        check("t1_done_hi", done, 1);
        step();
        check("t1_done_lo", done, 0);
        pop_chk("t1_word", {1'b1, 32'h84838281});

        // rounding shift
        do_start(5'd4, 1'b0);
        send_chk("t2_s1", 32'd24, 0);
        send_chk("t2_s2", -32'sd24, 0);
        send_chk("t2_s3", 32'd8, 0);
        send_chk("t2_s4", -32'sd9, 1);
        wait_done("t2_done");
        pop_chk("t2_word", {1'b1, 32'h7F817F82});

        // saturation, then relu
        do_start(5'd0, 1'b0);
        send_chk("t3_s1", 32'd1000, 0);
        send_chk("t3_s2", -32'sd1000, 1);
        wait_done("t3_done");
        pop_chk("t3_word", {1'b1, 32'h000000FF});
        do_start(5'd0, 1'b1);
        send_chk("t3_s3", -32'sd5, 0);
        send_chk("t3_s4", 32'd300, 1);
        wait_done("t3r_done");
        pop_chk("t3r_word", {1'b1, 32'h0000FF80});

        // partial flush; a start mid-run with new config must be ignored
        do_start(5'd0, 1'b0);
        send_chk("t4_s1", 32'd1, 0);
        send_chk("t4_s2", 32'd2, 0);
        do_start(5'd4, 1'b1);
        send_chk("t4_s3", 32'd3, 0);
        send_chk("t4_s4", 32'd4, 0);
        send_chk("t4_s5", 32'd5, 0);
        send_chk("t4_s6", 32'd6, 1);
        wait_done("t4_done");
        pop_chk("t4_w0", {1'b0, 32'h84838281});
        pop_chk("t4_w1", {1'b1, 32'h00008685});
        check("t4_qempty", q.size(), 0);

        // backpressure: two full words fill the FIFO, the 9th value stalls
        out_ready = 1'b0;
        acc_cnt   = 0;
        do_start(5'd0, 1'b0);
        for (int i = 1; i <= 8; i++) send_chk("t5_fill", 32'(i), 0);
        send(32'd9, 0, 10, ok);
        check("t5_stall", ok, 0);
        check("t5_acc8", acc_cnt, 8);
        check("t5_ready_lo", opsum_ready, 0);
        check("t5_full_valid", out_valid, 1);
        out_ready = 1'b1;
        for (int i = 9; i <= 12; i++) send_chk("t5_rest", 32'(i), (i == 12));
        wait_done("t5_done");
        check("t5_acc12", acc_cnt, 12);
        pop_chk("t5_w0", {1'b0, 32'h84838281});
        pop_chk("t5_w1", {1'b0, 32'h88878685});
        pop_chk("t5_w2", {1'b1, 32'h8C8B8A89});
        check("t5_qempty", q.size(), 0);

        // reset mid-run discards partial bytes
        do_start(5'd0, 1'b0);
        send_chk("t6_s1", 32'd100, 0);
        send_chk("t6_s2", 32'd101, 0);
        rst = 1'b0;
        #1;
        check("t6_ready", opsum_ready, 0);
        check("t6_valid", out_valid, 0);
        check("t6_data", out_data, 0);
        check("t6_done", done, 0);
        step();
        rst = 1'b1;
        step();
        do_start(5'd0, 1'b0);
        send_chk("t6_s3", 32'd5, 0);
        send_chk("t6_s4", 32'd6, 0);
        send_chk("t6_s5", 32'd7, 0);
        send_chk("t6_s6", 32'd8, 1);
        wait_done("t6_done2");
        pop_chk("t6_word", {1'b1, 32'h88878685});
        check("t6_qempty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
